// File: rtl/mem_io_responder_if.sv
// CPU-side memory bus of the memory/I-O responder.
// The CPU drives address, direction and write data; the responder returns read data.
interface mem_io_responder_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    modport master (
        output rdy_in,
        output mem_a,
        output mem_wr,
        output mem_dout,
        input  mem_din
    );

    modport slave (
        input  rdy_in,
        input  mem_a,
        input  mem_wr,
        input  mem_dout,
        output mem_din
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus a small I/O page (UART byte FIFOs, cycle counter snapshot, program stop)
// answering a simple CPU bus with one registered read cycle of latency.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic                rx_ready_o,
    output logic                program_stop_o,
    output logic                tx_overflow_o
);

    localparam int          PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          TX      = 0;
    localparam int          RX      = 1;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CNT  = 18'h30004;

    // ---------------------------------------------------------------- decode
    logic [17:0]               dec_a;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      unused_addr_hi;
    logic                      is_io;
    logic                      cpu_rd;
    logic                      cpu_wr;
    logic                      ram_we;
    logic                      ram_re;
    logic                      rd_uart;
    logic                      rd_cnt;
    logic                      io_wr_ok;
    logic                      wr_uart;
    logic                      wr_stop;

    assign dec_a          = bus.mem_a[17:0];
    assign ram_idx        = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    assign unused_addr_hi = ^bus.mem_a[31:18];
    assign is_io          = (dec_a[17:16] == 2'b11);
    assign cpu_rd         = bus.rdy_in & ~bus.mem_wr;
    assign cpu_wr         = bus.rdy_in &  bus.mem_wr;
    assign ram_we         = cpu_wr & ~is_io;
    assign ram_re         = cpu_rd & ~is_io;
    assign rd_uart        = cpu_rd & is_io & (dec_a == IO_UART);
    assign rd_cnt         = cpu_rd & is_io & (dec_a[17:2] == IO_CNT[17:2]);
    // Once the program has stopped, the whole I/O page becomes write-protected.
    assign io_wr_ok       = cpu_wr & is_io & ~program_stop_o;
    assign wr_uart        = io_wr_ok & (dec_a == IO_UART) & (bus.mem_dout != 8'h00);
    assign wr_stop        = io_wr_ok & (dec_a == IO_CNT);

    // ---------------------------------------------------------------- byte RAM
    logic [7:0] ram_mem [2**RAM_ADDR_WIDTH];
    logic [7:0] ram_rd_q;

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= bus.mem_dout;
        end
        if (ram_re) begin
            ram_rd_q <= ram_mem[ram_idx];
        end
    end

    // ---------------------------------------------------------------- FIFOs
    logic [1:0] fifo_push;
    logic [1:0] fifo_pop;
    logic [1:0] fifo_full;
    logic [1:0] fifo_empty;
    logic [1:0] fifo_drop;
    logic [7:0] fifo_wdata [2];
    logic [7:0] fifo_rdata [2];
    logic       tx_push;
    logic       tx_pop;
    logic       rx_push;
    logic       rx_pop;

    assign tx_push          = wr_uart | wr_stop;
    assign tx_pop           = ~fifo_empty[TX] & tx_ready_i;
    assign rx_push          = rx_valid_i & ~fifo_full[RX];
    assign rx_pop           = rd_uart & ~fifo_empty[RX];
    assign fifo_push        = {rx_push, tx_push};
    assign fifo_pop         = {rx_pop, tx_pop};
    assign fifo_wdata[TX]   = wr_stop ? 8'h00 : bus.mem_dout;
    assign fifo_wdata[RX]   = rx_data_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [7:0]   store [FIFO_DEPTH];
            logic [PTR_W:0] wr_ptr_q;
            logic [PTR_W:0] wr_ptr_d;
            logic [PTR_W:0] rd_ptr_q;
            logic [PTR_W:0] rd_ptr_d;
            logic           do_push;

            assign fifo_empty[gi] = (wr_ptr_q == rd_ptr_q);
            assign fifo_full[gi]  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
            // A full FIFO still accepts a byte when its head leaves on the same edge.
            assign do_push        = fifo_push[gi] & (~fifo_full[gi] | fifo_pop[gi]);
            assign fifo_drop[gi]  = fifo_push[gi] & fifo_full[gi] & ~fifo_pop[gi];
            assign fifo_rdata[gi] = store[rd_ptr_q[PTR_W-1:0]];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (do_push) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (fifo_pop[gi]) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            always_ff @(posedge clk_in) begin
                if (do_push) begin
                    store[wr_ptr_q[PTR_W-1:0]] <= fifo_wdata[gi];
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------- control state
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] snap_q;
    logic [31:0] snap_d;
    logic [7:0]  io_rd_q;
    logic [7:0]  io_rd_d;
    logic        sel_ram_q;
    logic        sel_ram_d;
    logic        stop_q;
    logic        stop_d;
    logic        ovf_q;
    logic        ovf_d;

    always_comb begin
        cnt_d     = cnt_q + 32'd1;
        snap_d    = snap_q;
        io_rd_d   = io_rd_q;
        sel_ram_d = sel_ram_q;
        stop_d    = stop_q | wr_stop;
        ovf_d     = ovf_q | fifo_drop[TX];
        // Read data only moves on a CPU read; writes and paused cycles hold mem_din.
        if (cpu_rd) begin
            sel_ram_d = ~is_io;
            io_rd_d   = 8'h00;
            if (rx_pop) begin
                io_rd_d = fifo_rdata[RX];
            end
            if (rd_cnt) begin
                case (dec_a[1:0])
                    2'd0: begin
                        snap_d  = cnt_q;
                        io_rd_d = cnt_q[7:0];
                    end
                    2'd1:    io_rd_d = snap_q[15:8];
                    2'd2:    io_rd_d = snap_q[23:16];
                    default: io_rd_d = snap_q[31:24];
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            snap_q    <= '0;
            io_rd_q   <= '0;
            sel_ram_q <= 1'b0;
            stop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            io_rd_q   <= io_rd_d;
            sel_ram_q <= sel_ram_d;
            stop_q    <= stop_d;
            ovf_q     <= ovf_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.mem_din     = sel_ram_q ? ram_rd_q : io_rd_q;
    assign tx_data_o       = fifo_rdata[TX];
    assign tx_valid_o      = ~fifo_empty[TX];
    assign rx_ready_o      = ~fifo_full[RX];
    assign program_stop_o  = stop_q;
    assign tx_overflow_o   = ovf_q;

endmodule
